micro_op_queue: RTL and testbench

- Buffers cracked micro-op groups from the decoder's micro-op generator (0..MAX_MOPS micro-ops per macro-instruction) in a circular queue.
- Issues up to ISSUE_W micro-ops per cycle in program order to the rename/dispatch stage.
- Adds what the combinational cracker lacks: atomic group enqueue, backpressure, per-op end-of-instruction marking, variable-width dequeue and pipeline flush.

---
 rtl/micro_op_queue_pkg.sv | 15 +
 rtl/mop_queue_ram.sv | 30 +++
 rtl/micro_op_queue.sv | 92 +++++++++
 tb/tb_micro_op_queue.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/micro_op_queue_pkg.sv
// Shared micro-op types and queue defaults for the decode -> rename micro-op path.
package micro_op_queue_pkg;
  localparam int MAX_MOP_CNT = 6;
  localparam int DEF_ISSUE_W = 2;
  localparam int QUEUE_DEPTH = 16;

  typedef logic [127:0] micro_op_t;

  typedef struct packed {
    micro_op_t mop;
    logic      last;
  } mop_entry_t;

  typedef micro_op_t mop_group_t [0:MAX_MOP_CNT-1];
endpackage

// File: rtl/mop_queue_ram.sv
// Circular entry storage: NWR write ports and NRD read ports, each at consecutive
// addresses from a base that wraps modulo DEPTH (DEPTH is a power of two).
module mop_queue_ram import micro_op_queue_pkg::*; #(
  parameter int EW    = $bits(mop_entry_t),
  parameter int NWR   = MAX_MOP_CNT,
  parameter int NRD   = DEF_ISSUE_W,
  parameter int DEPTH = QUEUE_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [NWR-1:0]    i_wr_en,
  input  logic [AW-1:0]     i_wr_base,
  input  logic [NWR*EW-1:0] i_wr_data,
  input  logic [AW-1:0]     i_rd_base,
  output logic [NRD*EW-1:0] o_rd_data
);
  logic [EW-1:0] r_mem [DEPTH];

  // AW-bit address sums wrap naturally, so groups straddling the end just work.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NWR; j++)
      if (i_wr_en[j]) r_mem[i_wr_base + AW'(j)] <= i_wr_data[j*EW +: EW];
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] w_addr;
    assign w_addr = i_rd_base + AW'(k);
    assign o_rd_data[k*EW +: EW] = r_mem[w_addr];
  end
endmodule

// File: rtl/micro_op_queue.sv
// Micro-op queue: atomic group enqueue from the cracker, in-order variable-width
// issue to rename, flush on redirect, one-cycle err pulse on protocol misuse.
module micro_op_queue import micro_op_queue_pkg::*; #(
  parameter int MOP_W    = $bits(micro_op_t),
  parameter int MAX_MOPS = MAX_MOP_CNT,
  parameter int ISSUE_W  = DEF_ISSUE_W,
  parameter int DEPTH    = QUEUE_DEPTH,
  localparam int CW = $clog2(MAX_MOPS+1),
  localparam int TW = $clog2(ISSUE_W+1),
  localparam int PW = $clog2(DEPTH),
  localparam int NW = $clog2(DEPTH+1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [CW-1:0]            in_cnt,
  input  logic [MAX_MOPS*MOP_W-1:0] in_mops,
  output logic                     in_ready,
  output logic [ISSUE_W-1:0]       out_valid,
  output logic [ISSUE_W*MOP_W-1:0] out_mops,
  output logic [ISSUE_W-1:0]       out_last,
  input  logic [TW-1:0]            out_take,
  output logic [NW-1:0]            count,
  output logic                     err
);
  localparam int EW = MOP_W + 1;

  logic [PW-1:0] r_head, r_tail;
  logic [NW-1:0] r_count;
  logic          r_err;

  logic                 w_in_ready, w_enq, w_cnt_err, w_take_err;
  logic [CW-1:0]        w_enq_cnt;
  logic [TW-1:0]        w_avail, w_eff_take;
  logic [MAX_MOPS-1:0]  w_wr_en;
  logic [MAX_MOPS*EW-1:0] w_wr_data;
  logic [ISSUE_W*EW-1:0]  w_rd_data;

  // Readiness looks only at registered occupancy; a same-cycle dequeue doesn't help.
  assign w_in_ready = (NW'(DEPTH) - r_count) >= NW'(MAX_MOPS);
  assign w_enq      = in_valid && w_in_ready && !flush && (in_cnt <= CW'(MAX_MOPS));
  assign w_cnt_err  = in_valid && w_in_ready && (in_cnt > CW'(MAX_MOPS));
  assign w_enq_cnt  = w_enq ? in_cnt : '0;

  assign w_avail    = (r_count < NW'(ISSUE_W)) ? TW'(r_count) : TW'(ISSUE_W);
  assign w_take_err = out_take > w_avail;
  assign w_eff_take = w_take_err ? w_avail : out_take;

  always_comb begin
    w_wr_en   = '0;
    w_wr_data = '0;
    for (int j = 0; j < MAX_MOPS; j++) begin
      w_wr_en[j] = w_enq && (CW'(j) < in_cnt);
      w_wr_data[j*EW +: EW] = {in_mops[j*MOP_W +: MOP_W], (CW'(j) == in_cnt - 1'b1)};
    end
  end

  mop_queue_ram #(.EW(EW), .NWR(MAX_MOPS), .NRD(ISSUE_W), .DEPTH(DEPTH)) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_base (r_tail),
    .i_wr_data (w_wr_data),
    .i_rd_base (r_head),
    .o_rd_data (w_rd_data)
  );

  for (genvar i = 0; i < ISSUE_W; i++) begin : g_out
    assign out_valid[i]               = r_count > NW'(i);
    assign out_mops[i*MOP_W +: MOP_W] = w_rd_data[i*EW+1 +: MOP_W];
    assign out_last[i]                = w_rd_data[i*EW];
  end

  // Flush and reset both empty the queue and suppress any err from that cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_head  <= r_head + PW'(w_eff_take);
      r_tail  <= r_tail + PW'(w_enq_cnt);
      r_count <= r_count + NW'(w_enq_cnt) - NW'(w_eff_take);
      r_err   <= w_take_err || w_cnt_err;
    end
  end

  assign in_ready = w_in_ready;
  assign count    = r_count;
  assign err      = r_err;
endmodule

// File: tb/tb_micro_op_queue.sv
// Directed bench for micro_op_queue: each task drives a scenario and checks inline.
module tb_micro_op_queue;
  localparam int MW = 128;

  logic           clk = 1'b0;
  logic           reset, flush, in_valid;
  logic [2:0]     in_cnt;
  logic [6*MW-1:0] in_mops;
  logic           in_ready;
  logic [1:0]     out_valid, out_last, out_take;
  logic [2*MW-1:0] out_mops;
  logic [4:0]     count;
  logic           err;

  int n_checks = 0;
  int n_fail   = 0;

  micro_op_queue dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_cnt(in_cnt),
    .in_mops(in_mops), .in_ready(in_ready), .out_valid(out_valid), .out_mops(out_mops),
    .out_last(out_last), .out_take(out_take), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [MW-1:0] mk(input int g, input int s);
    mk = {32'hC0DE_0000, 32'(g), 32'(s), 32'h5A5A_A5A5};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic put(input int g, input int cnt);
    in_mops = '0;
    for (int s = 0; s < cnt && s < 6; s++) in_mops[s*MW +: MW] = mk(g, s);
    in_cnt   = 3'(cnt);
    in_valid = 1'b1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_cnt = '0; out_take = '0; flush = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1; step(); step(); reset = 1'b0;
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL reset_out_valid got %b exp 00", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
  endtask

  task automatic test_basic();
    put(1, 4); step(); idle();
    n_checks++; if (count !== 5'd4) begin n_fail++; $display("FAIL basic_count got %0d exp 4", count); end
    n_checks++; if (out_valid !== 2'b11) begin n_fail++; $display("FAIL basic_out_valid got %b exp 11", out_valid); end
    n_checks++; if (out_mops !== {mk(1,1), mk(1,0)}) begin n_fail++; $display("FAIL basic_mops got %h exp %h", out_mops, {mk(1,1), mk(1,0)}); end
    n_checks++; if (out_last !== 2'b00) begin n_fail++; $display("FAIL basic_last got %b exp 00", out_last); end
    out_take = 2'd2; step();
    n_checks++; if (out_mops !== {mk(1,3), mk(1,2)} || out_last !== 2'b10) begin
      n_fail++; $display("FAIL basic_tail_ops got %h/%b exp %h/10", out_mops, out_last, {mk(1,3), mk(1,2)}); end
    step(); idle();
    n_checks++; if (count !== 5'd0 || out_valid !== 2'b00) begin n_fail++; $display("FAIL basic_drain got %0d/%b exp 0/00", count, out_valid); end
  endtask

  task automatic test_fill();
    put(2, 6); step(); put(3, 6); step();
    n_checks++; if (count !== 5'd12) begin n_fail++; $display("FAIL fill_count12 got %0d exp 12", count); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready_low got %b exp 0", in_ready); end
    put(4, 6);
    for (int c = 0; c < 5; c++) step();
    n_checks++; if (count !== 5'd12) begin n_fail++; $display("FAIL fill_held got %0d exp 12", count); end
    out_take = 2'd2; step(); out_take = '0;
    n_checks++; if (count !== 5'd10 || in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_take got %0d/%b exp 10/1", count, in_ready); end
    step(); idle();
    n_checks++; if (count !== 5'd16 || in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full got %0d/%b exp 16/0", count, in_ready); end
    n_checks++; if (out_mops !== {mk(2,3), mk(2,2)}) begin n_fail++; $display("FAIL fill_head got %h exp %h", out_mops, {mk(2,3), mk(2,2)}); end
    out_take = 2'd2;
    for (int c = 0; c < 5; c++) step();
    n_checks++; if (out_mops !== {mk(4,1), mk(4,0)} || count !== 5'd6) begin
      n_fail++; $display("FAIL fill_group4 got %h/%0d exp %h/6", out_mops, count, {mk(4,1), mk(4,0)}); end
    for (int c = 0; c < 3; c++) step();
    idle();
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL fill_drain got %0d exp 0", count); end
  endtask

  task automatic test_wrap();
    // head = tail = 6 here; 8 filler ops bring tail to 14
    put(5, 6); step(); put(6, 2); step(); put(7, 4); step(); idle();
    n_checks++; if (count !== 5'd12) begin n_fail++; $display("FAIL wrap_count got %0d exp 12", count); end
    out_take = 2'd2;
    for (int c = 0; c < 4; c++) step();
    n_checks++; if (out_mops !== {mk(7,1), mk(7,0)} || out_last !== 2'b00) begin
      n_fail++; $display("FAIL wrap_AB got %h/%b exp %h/00", out_mops, out_last, {mk(7,1), mk(7,0)}); end
    step();
    n_checks++; if (out_mops !== {mk(7,3), mk(7,2)} || out_last !== 2'b10) begin
      n_fail++; $display("FAIL wrap_CD got %h/%b exp %h/10", out_mops, out_last, {mk(7,3), mk(7,2)}); end
    step(); out_take = '0; put(9, 1); step(); idle();
    n_checks++; if (count !== 5'd1 || out_valid !== 2'b01 || out_mops[MW-1:0] !== mk(9,0) || out_last[0] !== 1'b1) begin
      n_fail++; $display("FAIL wrap_tail2 got %0d/%b/%h exp 1/01/%h", count, out_valid, out_mops[MW-1:0], mk(9,0)); end
  endtask

  task automatic test_simul();
    put(8, 2); step();
    n_checks++; if (count !== 5'd3) begin n_fail++; $display("FAIL simul_pre got %0d exp 3", count); end
    put(10, 2); out_take = 2'd2; step(); idle();
    n_checks++; if (count !== 5'd3) begin n_fail++; $display("FAIL simul_count got %0d exp 3", count); end
    n_checks++; if (out_mops !== {mk(10,0), mk(8,1)} || out_last !== 2'b01) begin
      n_fail++; $display("FAIL simul_order got %h/%b exp %h/01", out_mops, out_last, {mk(10,0), mk(8,1)}); end
    put(11, 0); step(); idle();
    n_checks++; if (count !== 5'd3 || err !== 1'b0) begin n_fail++; $display("FAIL nop got %0d/%b exp 3/0", count, err); end
  endtask

  task automatic test_errors();
    put(12, 6); in_cnt = 3'd7; step(); idle();
    n_checks++; if (count !== 5'd3 || err !== 1'b1) begin n_fail++; $display("FAIL badcnt got %0d/%b exp 3/1", count, err); end
    step();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL badcnt_pulse got %b exp 0", err); end
    out_take = 2'd2; step();
    n_checks++; if (count !== 5'd1 || err !== 1'b0) begin n_fail++; $display("FAIL take_legal got %0d/%b exp 1/0", count, err); end
    step(); idle();
    n_checks++; if (count !== 5'd0 || err !== 1'b1 || out_valid !== 2'b00) begin
      n_fail++; $display("FAIL overtake got %0d/%b/%b exp 0/1/00", count, err, out_valid); end
    step();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL overtake_pulse got %b exp 0", err); end
  endtask

  task automatic test_flush();
    put(13, 6); step(); put(14, 3); step(); idle();
    n_checks++; if (count !== 5'd9) begin n_fail++; $display("FAIL flush_pre got %0d exp 9", count); end
    put(15, 3); out_take = 2'd2; flush = 1'b1; step(); idle();
    n_checks++; if (count !== 5'd0 || out_valid !== 2'b00 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush got %0d/%b/%b exp 0/00/1", count, out_valid, in_ready); end
    out_take = 2'd2; flush = 1'b1; step(); idle();
    n_checks++; if (err !== 1'b0 || count !== 5'd0) begin n_fail++; $display("FAIL flush_noerr got %b/%0d exp 0/0", err, count); end
    put(16, 2); step(); idle();
    n_checks++; if (out_mops !== {mk(16,1), mk(16,0)} || count !== 5'd2) begin
      n_fail++; $display("FAIL flush_restart got %h/%0d exp %h/2", out_mops, count, {mk(16,1), mk(16,0)}); end
  endtask

  task automatic test_reset_mid();
    put(17, 3); step(); idle();
    n_checks++; if (count !== 5'd5) begin n_fail++; $display("FAIL rstmid_pre got %0d exp 5", count); end
    put(18, 3); out_take = 2'd3; reset = 1'b1; step(); idle();
    n_checks++; if (count !== 5'd0 || out_valid !== 2'b00 || in_ready !== 1'b1 || err !== 1'b0) begin
      n_fail++; $display("FAIL rstmid got %0d/%b/%b/%b exp 0/00/1/0", count, out_valid, in_ready, err); end
    step();
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL rstmid_hold got %0d exp 0", count); end
  endtask

  initial begin
    idle(); reset = 1'b1; in_mops = '0;
    test_reset();
    test_basic();
    test_fill();
    test_wrap();
    test_simul();
    test_errors();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
